// File: rtl/sys_skew.sv
// sys_skew: diagonal input-skew stage in front of the systolic array.
// Lane i delays its element by i+1 register stages so that the array sees
// a wavefront. Rows are grouped into tiles of SYS_ARRAY_LEN rows. While the
// last tile drains, new rows are held off, and tile_done marks the cycle in
// which the final element of the tile leaves the last lane.
module sys_skew #(
  parameter int SYS_ARRAY_LEN = 8,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SYS_ARRAY_LEN-1:0][DATA_WIDTH-1:0]  in_data,
  output logic [SYS_ARRAY_LEN-1:0][DATA_WIDTH-1:0]  out_data,
  output logic [SYS_ARRAY_LEN-1:0]                  out_valid,
  output logic                                      busy,
  output logic                                      tile_done
);

  // Counters need at least one bit, even for a single-lane array.
  localparam int CW = (SYS_ARRAY_LEN > 1) ? $clog2(SYS_ARRAY_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(SYS_ARRAY_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   row_cnt_reg;
  logic [CW-1:0]   drain_cnt_reg;
  logic            accept;

  // Ready depends on state only, so there is no path from in_valid.
  assign in_ready  = (state_reg != DRAIN);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_reg != IDLE);
  assign tile_done = (state_reg == DRAIN) && (drain_cnt_reg == LAST);

  // Tile sequencing: count accepted rows, then hold off input for L drain cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      row_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            drain_cnt_reg <= '0;
            if (SYS_ARRAY_LEN == 1) begin
              // A single row is already a complete tile.
              state_reg   <= DRAIN;
              row_cnt_reg <= '0;
            end else begin
              state_reg   <= FILL;
              row_cnt_reg <= CW'(1);
            end
          end
        end
        FILL: begin
          if (accept) begin
            if (row_cnt_reg == LAST) begin
              state_reg     <= DRAIN;
              row_cnt_reg   <= '0;
              drain_cnt_reg <= '0;
            end else begin
              row_cnt_reg <= row_cnt_reg + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == LAST) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          row_cnt_reg   <= '0;
          drain_cnt_reg <= '0;
        end
      endcase
    end
  end

  // One shift chain per lane; lane gi holds gi+1 {valid, data} stages.
  genvar gi;
  generate
    for (gi = 0; gi < SYS_ARRAY_LEN; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] data_reg [0:gi];
      logic [gi:0]           valid_reg;

      // Stage 0 takes the accepted element or a zero bubble; later stages shift.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j <= gi; j++) begin
            data_reg[j] <= '0;
          end
          valid_reg <= '0;
        end else begin
          valid_reg[0] <= accept;
          data_reg[0]  <= accept ? in_data[gi] : '0;
          for (int j = 1; j <= gi; j++) begin
            valid_reg[j] <= valid_reg[j-1];
            data_reg[j]  <= data_reg[j-1];
          end
        end
      end

      assign out_data[gi]  = data_reg[gi];
      assign out_valid[gi] = valid_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_sys_skew.sv
// tb_sys_skew: table-driven check of the skew stage at L=4, followed by a
// short hand-written sequence on a single-lane instance. Each table row holds
// one cycle's inputs and the outputs expected during that same cycle.
module tb_sys_skew;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // L=4 instance
  logic              in_valid;
  logic              in_ready;
  logic [3:0][15:0]  in_data;
  logic [3:0][15:0]  out_data;
  logic [3:0]        out_valid;
  logic              busy;
  logic              tile_done;

  // L=1 instance
  logic              l1_in_valid;
  logic              l1_in_ready;
  logic [0:0][15:0]  l1_in_data;
  logic [0:0][15:0]  l1_out_data;
  logic [0:0]        l1_out_valid;
  logic              l1_busy;
  logic              l1_tile_done;

  sys_skew #(.SYS_ARRAY_LEN(4), .DATA_WIDTH(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .tile_done (tile_done)
  );

  sys_skew #(.SYS_ARRAY_LEN(1), .DATA_WIDTH(16)) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (l1_in_valid),
    .in_ready  (l1_in_ready),
    .in_data   (l1_in_data),
    .out_data  (l1_out_data),
    .out_valid (l1_out_valid),
    .busy      (l1_busy),
    .tile_done (l1_tile_done)
  );

  // Expected lane data of 0 means that lane is expected invalid this cycle;
  // all stimulus values are nonzero.
  typedef struct packed {
    logic             rst;
    logic             iv;
    logic [3:0][15:0] d;
    logic             rdy;
    logic             bsy;
    logic             done;
    logic [3:0][15:0] e;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [3:0][15:0] R(input int a, input int b, input int c, input int d);
    logic [3:0][15:0] r;
    r[0] = 16'(a);
    r[1] = 16'(b);
    r[2] = 16'(c);
    r[3] = 16'(d);
    return r;
  endfunction

  task automatic add(input logic r, input logic iv, input logic [3:0][15:0] d,
                     input logic rdy, input logic bsy, input logic done,
                     input logic [3:0][15:0] e);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.rdy = rdy; v.bsy = bsy; v.done = done; v.e = e;
    vecs.push_back(v);
  endtask

  // Four gap-free rows and the four drain cycles; during drain the bench
  // optionally holds in_valid high with 99s, which must never be accepted.
  task automatic add_tile(input logic junk);
    logic [3:0][15:0] dd;
    dd = junk ? R(99, 99, 99, 99) : R(0, 0, 0, 0);
    add(0, 1, R(1, 2, 3, 4),     1, 0, 0, R(0, 0, 0, 0));
    add(0, 1, R(5, 6, 7, 8),     1, 1, 0, R(1, 0, 0, 0));
    add(0, 1, R(9, 10, 11, 12),  1, 1, 0, R(5, 2, 0, 0));
    add(0, 1, R(13, 14, 15, 16), 1, 1, 0, R(9, 6, 3, 0));
    add(0, junk, dd,             0, 1, 0, R(13, 10, 7, 4));
    add(0, junk, dd,             0, 1, 0, R(0, 14, 11, 8));
    add(0, junk, dd,             0, 1, 0, R(0, 0, 15, 12));
    add(0, junk, dd,             0, 1, 1, R(0, 0, 0, 16));
  endtask

  task automatic chk1(input string nm, input logic er, input logic ev,
                      input logic [15:0] ed, input logic eb, input logic edn);
    n_vec++;
    if ({l1_in_ready, l1_out_valid[0], l1_out_data[0], l1_busy, l1_tile_done} !==
        {er, ev, ed, eb, edn}) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b v=%b d=%h busy=%b done=%b, want rdy=%b v=%b d=%h busy=%b done=%b",
               nm, l1_in_ready, l1_out_valid[0], l1_out_data[0], l1_busy, l1_tile_done,
               er, ev, ed, eb, edn);
    end else begin
      $display("%s: rdy=%b v=%b d=%h busy=%b done=%b ok",
               nm, l1_in_ready, l1_out_valid[0], l1_out_data[0], l1_busy, l1_tile_done);
    end
  endtask

  initial begin
    logic [70:0] got;
    logic [70:0] exp;
    logic [3:0]  ev;

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    l1_in_valid = 1'b0; l1_in_data = '0;
    repeat (2) @(negedge clk);

    // Reset state, then tile 1; tile 2 starts the cycle after tile_done and
    // carries 99s during its drain; then a tile with a bubble after row 2.
    add(0, 0, R(0, 0, 0, 0), 1, 0, 0, R(0, 0, 0, 0));
    add_tile(1'b0);
    add_tile(1'b1);
    add(0, 1, R(1, 2, 3, 4),     1, 0, 0, R(0, 0, 0, 0));
    add(0, 1, R(5, 6, 7, 8),     1, 1, 0, R(1, 0, 0, 0));
    add(0, 0, R(0, 0, 0, 0),     1, 1, 0, R(5, 2, 0, 0));
    add(0, 1, R(9, 10, 11, 12),  1, 1, 0, R(0, 6, 3, 0));
    add(0, 1, R(13, 14, 15, 16), 1, 1, 0, R(9, 0, 7, 4));
    add(0, 0, R(0, 0, 0, 0),     0, 1, 0, R(13, 10, 0, 8));
    add(0, 0, R(0, 0, 0, 0),     0, 1, 0, R(0, 14, 11, 0));
    add(0, 0, R(0, 0, 0, 0),     0, 1, 0, R(0, 0, 15, 12));
    add(0, 0, R(0, 0, 0, 0),     0, 1, 1, R(0, 0, 0, 16));
    // Reset mid-drain: partial tile discarded, no tile_done, then a clean tile.
    add(0, 1, R(1, 2, 3, 4),     1, 0, 0, R(0, 0, 0, 0));
    add(0, 1, R(5, 6, 7, 8),     1, 1, 0, R(1, 0, 0, 0));
    add(0, 1, R(9, 10, 11, 12),  1, 1, 0, R(5, 2, 0, 0));
    add(0, 1, R(13, 14, 15, 16), 1, 1, 0, R(9, 6, 3, 0));
    add(0, 0, R(0, 0, 0, 0),     0, 1, 0, R(13, 10, 7, 4));
    add(1, 0, R(0, 0, 0, 0),     0, 1, 0, R(0, 14, 11, 8));
    add(0, 0, R(0, 0, 0, 0),     1, 0, 0, R(0, 0, 0, 0));
    add(0, 0, R(0, 0, 0, 0),     1, 0, 0, R(0, 0, 0, 0));
    add_tile(1'b0);
    add(0, 0, R(0, 0, 0, 0),     1, 0, 0, R(0, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      in_valid = vecs[i].iv;
      in_data  = vecs[i].d;
      #1;
      for (int k = 0; k < 4; k++) ev[k] = (vecs[i].e[k] != 16'd0);
      got = {in_ready, busy, tile_done, out_valid, out_data};
      exp = {vecs[i].rdy, vecs[i].bsy, vecs[i].done, ev, vecs[i].e};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL vec %0d: got rdy/busy/done/valid/data=%h, want %h", i, got, exp);
      end else begin
        $display("vec %0d: rdy=%b busy=%b done=%b valid=%b data=%h ok",
                 i, in_ready, busy, tile_done, out_valid, out_data);
      end
    end

    // Single-lane instance: one-row tiles, ready low only in the tile_done cycle.
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    l1_in_valid = 1'b1; l1_in_data[0] = 16'h000a; #1;
    chk1("l1 idle accept", 1, 0, 16'h0000, 0, 0);
    @(negedge clk); l1_in_valid = 1'b1; l1_in_data[0] = 16'h000b; #1;
    chk1("l1 drain done", 0, 1, 16'h000a, 1, 1);
    @(negedge clk); l1_in_valid = 1'b1; l1_in_data[0] = 16'h000b; #1;
    chk1("l1 idle again", 1, 0, 16'h0000, 0, 0);
    @(negedge clk); l1_in_valid = 1'b0; l1_in_data[0] = 16'h0000; #1;
    chk1("l1 second done", 0, 1, 16'h000b, 1, 1);
    @(negedge clk); #1;
    chk1("l1 final idle", 1, 0, 16'h0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_skew.md
# sys_skew

Input-skew stage between the operand fetcher and the systolic array. Accepts one row of `SYS_ARRAY_LEN` numbers per cycle with a valid strobe and emits them diagonally: lane i is delayed i cycles more than lane 0, so the array sees the wavefront it needs. It counts rows into a tile of `SYS_ARRAY_LEN` rows, back-pressures while the last tile drains, and pulses `tile_done` when the final element leaves lane `SYS_ARRAY_LEN-1`.

## Interface
- `SYS_ARRAY_LEN`, 8: lanes per row and rows per tile; must be ≥1.
- `DATA_WIDTH`, 16: bits per number.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `in_data` holds a row this cycle.
- `in_ready` output 1: stage accepts a row this cycle. Accept = `in_valid && in_ready`.
- `in_data` input `SYS_ARRAY_LEN` × `DATA_WIDTH`: row, element i goes to lane i.
- `out_data` output `SYS_ARRAY_LEN` × `DATA_WIDTH`: skewed lanes to the array.
- `out_valid` output `SYS_ARRAY_LEN` × 1: per-lane valid.
- `busy` output 1: high whenever state ≠ IDLE.
- `tile_done` output 1: one-cycle pulse, aligned with the last valid element on lane `SYS_ARRAY_LEN-1`.

## Operation
- Lane i is a shift chain of i+1 registers carrying {valid, data}. Stage 0 of every lane loads the accepted row element with valid=1. Otherwise it loads data=0, valid=0 (bubble).
- `out_data[i]`/`out_valid[i]` are the last register of lane i. Data is 0 whenever valid is 0.
- Row counter `row_cnt` (0..L-1) increments on each accept. Drain counter `drain_cnt` (0..L-1) increments each DRAIN cycle. L = `SYS_ARRAY_LEN`.
- States:
  - IDLE: `in_ready`=1. An accept moves to FILL with `row_cnt`=1. If L=1, it moves to DRAIN instead.
  - FILL: `in_ready`=1. `in_valid` low inserts a bubble and the counter holds. The accept that is the L-th row moves to DRAIN, clearing `row_cnt` and `drain_cnt`.
  - DRAIN: `in_ready`=0. `in_valid` is ignored and the chain keeps shifting bubbles. `tile_done` = (DRAIN && `drain_cnt`==L-1). On that cycle the next state is IDLE.
- A new tile can be accepted the cycle after `tile_done`. Tiles do not overlap.
- Reset, asserted anywhere including mid-FILL or mid-DRAIN: all chain registers are 0. The state goes to IDLE, counters to 0, `tile_done`=0, `busy`=0, `in_ready`=1 on the cycle after reset is sampled. The partial tile is discarded with no `tile_done`.
- Outputs on the cycle after reset: `out_data` all 0, `out_valid` all 0, `busy` 0, `tile_done` 0, `in_ready` 1.

## Timing
- A row accepted at edge t appears on lane i during cycle t+1+i, i.e. after i+1 edges.
- Tile accepted gap-free at edges t0..t0+L-1:
  - DRAIN is entered at cycle t0+L.
  - `tile_done` and the last `out_valid[L-1]` occur at cycle t0+2L-1.
  - IDLE is reached at t0+2L.
- With bubbles, `tile_done` stays exactly L-1 cycles after the L-th accept, plus 1 edge.
- `in_ready` depends only on state (no combinational path from `in_valid`).
- `tile_done` is combinational from registered state, so it is glitch-free at the edge.
- Width rules:
  - data passes unmodified, with no arithmetic.
  - `row_cnt` and `drain_cnt` are `$clog2(L)` bits, minimum 1.

## Test plan
- L=4, rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} accepted at t0..t0+3. Lane 0 shows 1,5,9,13 at t0+1..t0+4. Lane 3 shows 4,8,12,16 at t0+4..t0+7. `tile_done` fires only at t0+7, `in_ready` is low t0+4..t0+7, and `busy` drops at t0+8.
- L=4, bubble after row 2 (one idle cycle): lane outputs show a valid=0, data=0 gap, and `tile_done` moves one cycle later, to t0+8.
- `in_valid`=1 held with row {99,99,99,99} during DRAIN: no 99 ever appears on any lane, and the counters are unaffected.
- Reset pulsed for one cycle at t0+5 (mid-DRAIN): the next cycle has all `out_valid`=0, `busy`=0, `in_ready`=1. `tile_done` never fires, and a fresh tile afterwards behaves exactly as in scenario 1.
- Back-to-back tiles: the second tile's first accept is on the cycle after `tile_done`, and the second `tile_done` comes exactly 2L cycles after the first.
- L=1: each accepted row appears after 1 edge with `tile_done` in the same cycle, and `in_ready` is low exactly that one cycle.
